// File: rtl/fifo_rx_elink_pack_pkg.sv
// Shared constants for the e-link receive packer: character codes and packer states.
package fifo_rx_elink_pack_pkg;

    localparam logic [1:0] CODE_DATA  = 2'b00;
    localparam logic [1:0] CODE_EOP   = 2'b01;
    localparam logic [1:0] CODE_SOP   = 2'b10;
    localparam logic [1:0] CODE_COMMA = 2'b11;

    localparam logic [9:0] COMMA_CHAR = 10'b1100000000;

    // Low byte written with an odd-length EOP so the reader can spot the tail byte.
    localparam logic [7:0] ODD_TAIL_FLAG = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } pack_state_t;

endpackage

// File: rtl/fifo_rx_elink_pack_if.sv
// Character input, read port and status flags of the e-link receive FIFO.
interface fifo_rx_elink_pack_if #(
    parameter int DIN_W  = 10,
    parameter int DOUT_W = 18
);
    logic              fifoFLUSH;
    logic [DIN_W-1:0]  din;
    logic              din_rdy;
    logic              rd_en;
    logic [DOUT_W-1:0] dout;
    logic              doutRdy;
    logic              empty;
    logic              full;
    logic              prog_full;
    logic              proto_err;
    logic              overflow;

    modport master (
        output fifoFLUSH, din, din_rdy, rd_en,
        input  dout, doutRdy, empty, full, prog_full, proto_err, overflow
    );

    modport slave (
        input  fifoFLUSH, din, din_rdy, rd_en,
        output dout, doutRdy, empty, full, prog_full, proto_err, overflow
    );
endinterface

// File: rtl/fifo_rx_elink_pack_fifo.sv
// Single-clock FIFO with registered read data and flags derived from the stored count.
module elink_sync_fifo #(
    parameter int WIDTH            = 18,
    parameter int DEPTH            = 512,
    parameter int PROG_FULL_THRESH = 448
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_rdy,
    output logic             empty,
    output logic             full,
    output logic             prog_full,
    output logic             wr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(PROG_FULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd_ok;
    logic             wr_ok;

    // Accept decisions use the live count; the exported flags lag it by one cycle.
    // A read at full frees the slot that a same-cycle write then takes.
    assign rd_ok   = rd_en && (count != '0);
    assign wr_ok   = wr_en && ((count != DEPTH_C) || rd_ok);
    assign wr_drop = wr_en && !wr_ok;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, registered read data and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            dout_rdy  <= 1'b0;
            empty     <= 1'b1;
            full      <= 1'b0;
            prog_full <= 1'b0;
        end else begin
            dout_rdy <= rd_ok;
            if (rd_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count     <= count + CW'(wr_ok) - CW'(rd_ok);
            empty     <= (count == '0);
            full      <= (count == DEPTH_C);
            prog_full <= (count >= THRESH_C);
        end
    end

endmodule

// File: rtl/fifo_rx_elink_pack.sv
// E-link receive wrapper: strips commas, packs byte pairs into 18-bit words and buffers them.
module fifo_rx_elink_pack
    import fifo_rx_elink_pack_pkg::*;
#(
    parameter int DATA_IN_WIDTH    = 10,
    parameter int DATA_OUT_WIDTH   = 18,
    parameter int FIFO_DEPTH       = 512,
    parameter int PROG_FULL_THRESH = 448,
    parameter int module_enable    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rx_elink_pack_if.slave  bus
);
    localparam bit EN = (module_enable != 0);

    pack_state_t               state;
    logic [7:0]                byte_hi;
    logic                      wr_en_q;
    logic [DATA_OUT_WIDTH-1:0] wr_data_q;
    logic                      proto_err_q;
    logic                      overflow_q;

    logic                      clr;
    logic                      din_rdy_g;
    logic                      rd_en_g;
    logic [1:0]                code;
    logic [7:0]                byte_in;

    logic [DATA_OUT_WIDTH-1:0] fifo_dout;
    logic                      fifo_dout_rdy;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_prog_full;
    logic                      fifo_wr_drop;

    assign clr       = rst || (EN && bus.fifoFLUSH);
    assign din_rdy_g = EN && bus.din_rdy;
    assign rd_en_g   = EN && bus.rd_en;
    assign code      = bus.din[DATA_IN_WIDTH-1 -: 2];
    assign byte_in   = bus.din[7:0];

    // Packer FSM: one registered FIFO write at most per qualified character.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            byte_hi     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            proto_err_q <= 1'b0;
            if (din_rdy_g) begin
                case (code)
                    CODE_SOP: begin
                        // A repeated SOP restarts the packet and drops any half-built word.
                        if (state != ST_IDLE) begin
                            proto_err_q <= 1'b1;
                        end
                        byte_hi   <= '0;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= {CODE_SOP, 16'h0000};
                        state     <= ST_EVEN;
                    end
                    CODE_DATA: begin
                        case (state)
                            ST_IDLE: proto_err_q <= 1'b1;
                            ST_EVEN: begin
                                byte_hi <= byte_in;
                                state   <= ST_ODD;
                            end
                            ST_ODD: begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= {CODE_DATA, byte_hi, byte_in};
                                state     <= ST_EVEN;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    CODE_EOP: begin
                        case (state)
                            ST_IDLE: proto_err_q <= 1'b1;
                            ST_EVEN: begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= {CODE_EOP, 16'h0000};
                                state     <= ST_IDLE;
                            end
                            ST_ODD: begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= {CODE_EOP, byte_hi, ODD_TAIL_FLAG};
                                state     <= ST_IDLE;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky record of any word lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow_q <= 1'b0;
        end else if (fifo_wr_drop) begin
            overflow_q <= 1'b1;
        end
    end

    elink_sync_fifo #(
        .WIDTH            (DATA_OUT_WIDTH),
        .DEPTH            (FIFO_DEPTH),
        .PROG_FULL_THRESH (PROG_FULL_THRESH)
    ) u_fifo (
        .clk       (clk),
        .rst       (clr),
        .wr_en     (wr_en_q),
        .wr_data   (wr_data_q),
        .rd_en     (rd_en_g),
        .dout      (fifo_dout),
        .dout_rdy  (fifo_dout_rdy),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .prog_full (fifo_prog_full),
        .wr_drop   (fifo_wr_drop)
    );

    assign bus.dout      = EN ? fifo_dout      : '0;
    assign bus.doutRdy   = EN ? fifo_dout_rdy  : 1'b0;
    assign bus.empty     = EN ? fifo_empty     : 1'b1;
    assign bus.full      = EN ? fifo_full      : 1'b0;
    assign bus.prog_full = EN ? fifo_prog_full : 1'b0;
    assign bus.proto_err = EN ? proto_err_q    : 1'b0;
    assign bus.overflow  = EN ? overflow_q     : 1'b0;

endmodule

// File: tb/tb_fifo_rx_elink_pack.sv
// Directed bench for the e-link receive packer and its FIFO.
module tb_fifo_rx_elink_pack;
    import fifo_rx_elink_pack_pkg::*;

    typedef struct {
        logic [9:0]  din;
        logic        exp_perr;
        logic        exp_wr;
        logic [17:0] exp_word;
        logic        drain;
    } vec_t;

    localparam logic [9:0] C_SOP = 10'h200;
    localparam logic [9:0] C_EOP = 10'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    logic [17:0] sb[$];

    fifo_rx_elink_pack_if bus ();

    fifo_rx_elink_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [9:0] d, input logic perr, input logic wr,
                       input logic [17:0] w, input logic dr);
        vec_t v;
        v.din = d; v.exp_perr = perr; v.exp_wr = wr; v.exp_word = w; v.drain = dr;
        vecs.push_back(v);
    endtask

    // Present one character for one cycle; returns at the negedge after it was sampled.
    task automatic drive_char(input logic [9:0] d);
        bus.din     = d;
        bus.din_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.din_rdy = 1'b0;
        bus.din     = COMMA_CHAR;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_word(input logic [17:0] exp);
        bus.rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("read_rdy", 32'(bus.doutRdy), 32'd1);
        check("read_data", 32'(bus.dout), 32'(exp));
    endtask

    task automatic drain();
        while (sb.size() > 0) read_word(sb.pop_front());
        idle(2);
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        bus.fifoFLUSH = 1'b0;
        bus.din       = COMMA_CHAR;
        bus.din_rdy   = 1'b0;
        bus.rd_en     = 1'b0;

        // Comma stream
        for (int i = 0; i < 20; i++) add(COMMA_CHAR, 1'b0, 1'b0, 18'h0, (i == 19));
        // Even-length packet
        add(C_SOP,   1'b0, 1'b1, 18'h20000, 1'b0);
        add(10'h0AA, 1'b0, 1'b0, 18'h0,     1'b0);
        add(10'h0BB, 1'b0, 1'b1, 18'h0AABB, 1'b0);
        add(10'h0CC, 1'b0, 1'b0, 18'h0,     1'b0);
        add(10'h0DD, 1'b0, 1'b1, 18'h0CCDD, 1'b0);
        add(C_EOP,   1'b0, 1'b1, 18'h10000, 1'b1);
        // Odd-length packet with an embedded comma
        add(C_SOP,   1'b0, 1'b1, 18'h20000, 1'b0);
        add(10'h011, 1'b0, 1'b0, 18'h0,     1'b0);
        add(COMMA_CHAR, 1'b0, 1'b0, 18'h0,  1'b0);
        add(10'h022, 1'b0, 1'b1, 18'h01122, 1'b0);
        add(10'h033, 1'b0, 1'b0, 18'h0,     1'b0);
        add(C_EOP,   1'b0, 1'b1, 18'h13301, 1'b1);
        // Protocol errors
        add(10'h055, 1'b1, 1'b0, 18'h0,     1'b0);
        add(C_EOP,   1'b1, 1'b0, 18'h0,     1'b0);
        add(C_SOP,   1'b0, 1'b1, 18'h20000, 1'b0);
        add(10'h066, 1'b0, 1'b0, 18'h0,     1'b0);
        add(C_SOP,   1'b1, 1'b1, 18'h20000, 1'b0);
        add(C_EOP,   1'b0, 1'b1, 18'h10000, 1'b1);

        // Reset state
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_pfull", 32'(bus.prog_full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_rdy", 32'(bus.doutRdy), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_perr", 32'(bus.proto_err), 32'd0);

        // Table-driven packets
        foreach (vecs[i]) begin
            drive_char(vecs[i].din);
            check($sformatf("perr_v%0d", i), 32'(bus.proto_err), 32'(vecs[i].exp_perr));
            if (vecs[i].exp_wr) sb.push_back(vecs[i].exp_word);
            if (vecs[i].drain) drain();
        end

        // Fill to prog_full and full using back-to-back SOP words
        repeat (447) drive_char(C_SOP);
        idle(3);
        check("pfull_447", 32'(bus.prog_full), 32'd0);
        drive_char(C_SOP);
        idle(3);
        check("pfull_448", 32'(bus.prog_full), 32'd1);
        check("full_448", 32'(bus.full), 32'd0);
        repeat (64) drive_char(C_SOP);
        idle(3);
        check("full_512", 32'(bus.full), 32'd1);
        check("ovf_512", 32'(bus.overflow), 32'd0);

        // Read and write landing on the same edge while full
        drive_char(C_SOP);
        bus.rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("rw_full_rdy", 32'(bus.doutRdy), 32'd1);
        check("rw_full_dout", 32'(bus.dout), 32'h20000);
        idle(2);
        check("rw_full_full", 32'(bus.full), 32'd1);
        check("rw_full_ovf", 32'(bus.overflow), 32'd0);

        // One word too many
        drive_char(C_SOP);
        idle(2);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_full", 32'(bus.full), 32'd1);
        read_word(18'h20000);
        idle(2);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.full), 32'd0);

        // Flush while a byte is pending
        drive_char(10'h077);
        bus.fifoFLUSH = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.fifoFLUSH = 1'b0;
        check("flush_empty", 32'(bus.empty), 32'd1);
        check("flush_ovf", 32'(bus.overflow), 32'd0);
        check("flush_pfull", 32'(bus.prog_full), 32'd0);
        drive_char(10'h088);
        check("flush_idle_perr", 32'(bus.proto_err), 32'd1);

        // Read on empty is ignored
        bus.rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        check("rd_empty_rdy", 32'(bus.doutRdy), 32'd0);
        check("rd_empty_dout", 32'(bus.dout), 32'd0);

        // empty falls two cycles after the first character
        drive_char(C_SOP);
        check("empty_lag0", 32'(bus.empty), 32'd1);
        idle(1);
        check("empty_lag1", 32'(bus.empty), 32'd1);
        idle(1);
        check("empty_lag2", 32'(bus.empty), 32'd0);
        drive_char(C_EOP);
        sb.push_back(18'h20000);
        sb.push_back(18'h10000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
